// File: rtl/send_packet_arbiter_n_if.sv
// Send-packet arbiter bus: per-channel requests/PIDs in, registered grant and muxed PID/write-enable out.
// The arbiter connects through the slave modport; requesters connect through master.
interface send_packet_arbiter_n_if #(
  parameter int NUM_REQ   = 2,
  parameter int PID_WIDTH = 4,
  parameter int IDX_WIDTH = 3
) ();
  logic [NUM_REQ-1:0]           txReq;
  logic [NUM_REQ-1:0]           spWEnIn;
  logic [NUM_REQ*PID_WIDTH-1:0] pidIn;
  logic [NUM_REQ-1:0]           txGnt;
  logic                         gntValid;
  logic [IDX_WIDTH-1:0]         gntIdx;
  logic [PID_WIDTH-1:0]         sendPacketPID;
  logic                         sendPacketWEnable;

  modport master (
    output txReq, spWEnIn, pidIn,
    input  txGnt, gntValid, gntIdx, sendPacketPID, sendPacketWEnable
  );

  modport slave (
    input  txReq, spWEnIn, pidIn,
    output txGnt, gntValid, gntIdx, sendPacketPID, sendPacketWEnable
  );
endinterface

// File: rtl/send_packet_arbiter_n.sv
// NUM_REQ-way send-packet arbiter; channel 0 (SOF) has absolute priority over channels 1..NUM_REQ-1.
// Define SPA_ROUND_ROBIN_EN to arbitrate channels 1..NUM_REQ-1 round-robin instead of fixed priority.
module send_packet_arbiter_n #(
  parameter int NUM_REQ   = 2,
  parameter int PID_WIDTH = 4,
  parameter int IDX_WIDTH = 3
) (
  input logic                  clk,
  input logic                  rst,
  send_packet_arbiter_n_if.slave bus
);

  localparam int SLOTS = 2**IDX_WIDTH;

  typedef enum logic [1:0] {
    START    = 2'd0,
    WAIT_REQ = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic                 valid_reg, valid_next;
  logic [IDX_WIDTH-1:0] idx_reg, idx_next;
  logic [IDX_WIDTH-1:0] winner;
  logic                 any_req;

  // Inputs padded out to the full index range so gntIdx can index them directly.
  logic [PID_WIDTH-1:0] pid_slot [SLOTS];
  logic [SLOTS-1:0]     wen_slot;
  logic [SLOTS-1:0]     req_slot;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_REQ) begin : g_used
        assign pid_slot[gi] = bus.pidIn[gi*PID_WIDTH +: PID_WIDTH];
        assign wen_slot[gi] = bus.spWEnIn[gi];
        assign req_slot[gi] = bus.txReq[gi];
      end else begin : g_pad
        assign pid_slot[gi] = '0;
        assign wen_slot[gi] = 1'b0;
        assign req_slot[gi] = 1'b0;
      end
    end
  endgenerate

  assign any_req = |bus.txReq;

`ifdef SPA_ROUND_ROBIN_EN
  logic [IDX_WIDTH-1:0] rr_last_reg, rr_last_next;

  // Walk from the farthest candidate to the nearest so the one right after rr_last wins.
  always_comb begin
    int cand;
    cand   = 0;
    winner = '0;
    if (!bus.txReq[0]) begin
      for (int off = NUM_REQ-1; off >= 1; off--) begin
        cand = ((int'(rr_last_reg) - 1 + off) % (NUM_REQ-1)) + 1;
        if (req_slot[IDX_WIDTH'(cand)]) winner = IDX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    rr_last_next = rr_last_reg;
    if (state_reg == WAIT_REQ && any_req && winner != '0) rr_last_next = winner;
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_last_reg <= IDX_WIDTH'(NUM_REQ-1);
    else      rr_last_reg <= rr_last_next;
  end
`else
  always_comb begin
    winner = '0;
    if (!bus.txReq[0]) begin
      for (int k = NUM_REQ-1; k >= 1; k--) begin
        if (bus.txReq[k]) winner = IDX_WIDTH'(k);
      end
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    valid_next = valid_reg;
    idx_next   = idx_reg;
    case (state_reg)
      START: state_next = WAIT_REQ;
      WAIT_REQ: begin
        if (any_req) begin
          gnt_next   = NUM_REQ'(1) << winner;
          valid_next = 1'b1;
          idx_next   = winner;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Other channels, including SOF, wait until the owner lets go.
        if (!req_slot[idx_reg]) begin
          gnt_next   = '0;
          valid_next = 1'b0;
          state_next = WAIT_REQ;
        end
      end
      default: begin
        gnt_next   = '0;
        valid_next = 1'b0;
        state_next = START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= START;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
    end
  end

  assign bus.txGnt             = gnt_reg;
  assign bus.gntValid          = valid_reg;
  assign bus.gntIdx            = idx_reg;
  assign bus.sendPacketPID     = pid_slot[idx_reg];
  assign bus.sendPacketWEnable = wen_slot[idx_reg] & valid_reg;

endmodule

// File: tb/tb_send_packet_arbiter_n.sv
// Bench for send_packet_arbiter_n (NUM_REQ=4): directed scenarios plus random traffic, all checked
// every cycle against a behavioural owner/priority model.
module tb_send_packet_arbiter_n;
  localparam int N  = 4;
  localparam int PW = 4;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  send_packet_arbiter_n_if #(.NUM_REQ(N), .PID_WIDTH(PW), .IDX_WIDTH(IW)) bus ();

  send_packet_arbiter_n #(.NUM_REQ(N), .PID_WIDTH(PW), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the transmitter (-1 = nobody), whether the post-reset start cycle has passed,
  // the last granted channel, and the last round-robin winner among channels 1..N-1.
  bit m_started = 1'b0;
  int m_owner   = -1;
  int m_last    = 0;
  int m_rr      = N-1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] r);
    if (r[0]) return 0;
`ifdef SPA_ROUND_ROBIN_EN
    for (int off = 1; off < N; off++) begin
      int c;
      c = ((m_rr - 1 + off) % (N-1)) + 1;
      if (r[c]) return c;
    end
`else
    for (int c = 1; c < N; c++) if (r[c]) return c;
`endif
    return -1;
  endfunction

  task automatic compare_all();
    logic [N-1:0]    exp_gnt;
    logic [N*PW-1:0] pids;
    exp_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
    pids    = bus.pidIn;
    check("txGnt", 32'(bus.txGnt), 32'(exp_gnt));
    check("gntValid", 32'(bus.gntValid), 32'(m_owner >= 0));
    check("gntIdx", 32'(bus.gntIdx), 32'(m_last));
    check("sendPacketPID", 32'(bus.sendPacketPID), 32'(pids[m_last*PW +: PW]));
    check("sendPacketWEnable", 32'(bus.sendPacketWEnable),
          32'((m_owner >= 0) && bus.spWEnIn[m_last]));
  endtask

  // One clock: advance the model with the inputs the DUT sees at this edge, then compare.
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      m_started = 1'b0;
      m_owner   = -1;
      m_last    = 0;
      m_rr      = N-1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_owner >= 0) begin
      if (!bus.txReq[m_owner]) m_owner = -1;
    end else if (bus.txReq != '0) begin
      m_owner = pick(bus.txReq);
      m_last  = m_owner;
      if (m_owner != 0) m_rr = m_owner;
    end
    #1;
    compare_all();
  endtask

  int order [4];
  int exp_order [4];

  initial begin
    bus.txReq   = '1;
    bus.spWEnIn = '1;
    bus.pidIn   = {4'hC, 4'h9, 4'h3, 4'h5};

    // Reset held with every channel requesting.
    rst = 1'b0;
    repeat (3) cycle();
    check("rst_gnt", 32'(bus.txGnt), 32'h0);
    check("rst_wen", 32'(bus.sendPacketWEnable), 32'h0);
    rst = 1'b1;
    cycle();
    check("start_gnt", 32'(bus.txGnt), 32'h0);
    cycle();
    check("first_gnt", 32'(bus.txGnt), 32'b0001);
    bus.txReq = '0;
    repeat (2) cycle();

    // Fixed priority among 1..N-1, then one idle cycle before the next grant.
    bus.txReq = 4'b0110;
    cycle();
    check("prio_gnt", 32'(bus.txGnt), 32'b0010);
    check("prio_pid", 32'(bus.sendPacketPID), 32'h3);
    bus.txReq = 4'b0100;
    cycle();
    check("prio_idle", 32'(bus.txGnt), 32'h0);
    cycle();
    check("prio_next", 32'(bus.txGnt), 32'b0100);

    // SOF arriving during another grant waits for release.
    bus.txReq = 4'b0101;
    repeat (2) cycle();
    check("sof_wait", 32'(bus.txGnt), 32'b0100);
    bus.txReq = 4'b0001;
    cycle();
    check("sof_idle", 32'(bus.txGnt), 32'h0);
    cycle();
    check("sof_gnt", 32'(bus.txGnt), 32'b0001);
    check("sof_pid", 32'(bus.sendPacketPID), 32'h5);
    bus.txReq = '0;
    repeat (2) cycle();

    // Write-enable gating and same-cycle muxing.
    bus.spWEnIn = 4'b1111;
    #1 check("wen_idle", 32'(bus.sendPacketWEnable), 32'h0);
    bus.txReq = 4'b1000;
    cycle();
    bus.spWEnIn = 4'b0111;
    #1 check("wen_ch3_off", 32'(bus.sendPacketWEnable), 32'h0);
    bus.spWEnIn = 4'b1111;
    #1 check("wen_ch3_on", 32'(bus.sendPacketWEnable), 32'h1);
    bus.spWEnIn = 4'b1101;
    #1 check("wen_ch1_off", 32'(bus.sendPacketWEnable), 32'h1);
    bus.txReq = '0;
    repeat (2) cycle();

    // Grant order with channels 1..3 all requesting, each released by a one-cycle request pulse.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    bus.txReq = 4'b1110;
`ifdef SPA_ROUND_ROBIN_EN
    exp_order = '{1, 2, 3, 1};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    for (int g = 0; g < 4; g++) begin
      int waited;
      waited = 0;
      do begin
        cycle();
        waited++;
      end while (!bus.gntValid && waited < 8);
      check("order_timeout", 32'(bus.gntValid), 32'h1);
      order[g] = int'(bus.gntIdx);
      check($sformatf("order_%0d", g), 32'(order[g]), 32'(exp_order[g]));
      cycle();
      bus.txReq[order[g]] = 1'b0;
      cycle();
      bus.txReq[order[g]] = 1'b1;
    end
    bus.txReq = '0;
    repeat (3) cycle();

    // Reset in the middle of a grant.
    bus.txReq = 4'b0100;
    cycle();
    check("mid_gnt", 32'(bus.txGnt), 32'b0100);
    rst = 1'b0;
    cycle();
    check("mid_rst", 32'(bus.txGnt), 32'h0);
    rst = 1'b1;
    cycle();
    check("mid_start", 32'(bus.txGnt), 32'h0);
    cycle();
    check("mid_regnt", 32'(bus.txGnt), 32'b0100);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 4) == 0) bus.txReq[c] = ~bus.txReq[c];
      end
      bus.spWEnIn = N'($urandom);
      bus.pidIn   = (N*PW)'($urandom);
      rst = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
      cycle();
      if (bus.gntValid) begin
        bus.spWEnIn = N'($urandom);
        bus.pidIn   = (N*PW)'($urandom);
        #1 compare_all();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
